// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types. Adds the byte-to-word address shift used by
//               the main-memory model and a helper for its range checks.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // One machine word.
    typedef logic [31:0] word_t;

    // Handshake returned by main memory to the bus arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Byte address bits below this position select a byte inside a word.
    localparam int RAM_WORD_SHIFT = 2;

    // True when the word index carried by a byte address fits in a memory
    // holding 2**idx_w words, i.e. every bit above the index is zero.
    function automatic logic ram_addr_in_range(input word_t addr, input int idx_w);
        return ((addr >> (RAM_WORD_SHIFT + idx_w)) == '0);
    endfunction

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/ram_latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : ram_latency_counter
// Description : Per-transaction latency counter. Reports done in the cycle in
//               which the current transaction has spent LAT cycles in BUSY.
//               A start/restart makes the current cycle count as cycle 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_latency_counter #(
    parameter int LAT   = 4,
    parameter int CNT_W = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic start,    // first cycle of a transaction from idle
    input  logic restart,  // request changed while a transaction was active
    input  logic freeze,   // hold the count (debug ownership, error)
    input  logic clear,    // bus idle
    output logic done      // count has reached LAT in this cycle
);

    localparam logic [CNT_W-1:0] c_LAT = CNT_W'(LAT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cur;

    // A new transaction is at count 0 in the very cycle it begins, so the
    // registered value is bypassed on start/restart.
    assign w_cur = (start || restart) ? '0 : r_cnt;
    assign done  = (w_cur == c_LAT);

    // Advance once per BUSY cycle; wrap to 0 after the ACCESS cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (freeze) begin
            r_cnt <= r_cnt;
        end else if (done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cur + CNT_W'(1);
        end
    end

endmodule : ram_latency_counter
`default_nettype wire

// File: rtl/ram_latency_unit.sv
`default_nettype none
// ============================================================================
// Module      : ram_latency_unit
// Description : Word-addressed main-memory model behind the bus arbiter.
//               Answers each bus request with LAT BUSY cycles followed by one
//               ACCESS cycle, flags malformed/out-of-range requests as ERROR,
//               and offers a priority debug port for preload and dump.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_latency_unit
    import cpu_types_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int LAT   = 4,
    parameter int CNT_W = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    // bus side
    input  word_t     ramaddr,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate,
    // debug side
    input  logic      dbg_en,
    input  logic      dbg_wen,
    input  word_t     dbg_addr,
    input  word_t     dbg_store,
    output word_t     dbg_load
);

    localparam int c_IDX_W = $clog2(WORDS);

    // ------------------------------------------------------------------
    // Storage and address decode
    // ------------------------------------------------------------------
    word_t              r_mem [WORDS];

    logic [c_IDX_W-1:0] w_bus_idx;
    logic [c_IDX_W-1:0] w_dbg_idx;
    logic               w_bus_in_range;
    logic               w_dbg_in_range;
    logic               w_unused_bits;

    assign w_bus_idx      = ramaddr[RAM_WORD_SHIFT +: c_IDX_W];
    assign w_dbg_idx      = dbg_addr[RAM_WORD_SHIFT +: c_IDX_W];
    assign w_bus_in_range = ram_addr_in_range(ramaddr, c_IDX_W);
    assign w_dbg_in_range = ram_addr_in_range(dbg_addr, c_IDX_W);

    // Byte-select bits carry no meaning for a word-only memory.
    assign w_unused_bits  = ^{ramaddr[RAM_WORD_SHIFT-1:0], dbg_addr[RAM_WORD_SHIFT-1:0]};

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    logic w_req;
    logic w_err;
    logic w_valid;
    logic w_bus_go;     // a valid request the bus currently owns memory for
    logic w_changed;

    word_t r_snap_addr;
    word_t r_snap_store;
    logic  r_snap_ren;
    logic  r_snap_wen;
    logic  r_active;

    assign w_req     = ramREN || ramWEN;
    assign w_err     = w_req && ((ramREN && ramWEN) || !w_bus_in_range);
    assign w_valid   = w_req && !w_err;
    assign w_bus_go  = w_valid && !dbg_en;
    assign w_changed = {ramaddr, ramREN, ramWEN, ramstore}
                    != {r_snap_addr, r_snap_ren, r_snap_wen, r_snap_store};

    // ------------------------------------------------------------------
    // Latency counter
    // ------------------------------------------------------------------
    logic w_start;
    logic w_restart;
    logic w_freeze;
    logic w_clear;
    logic w_done;
    logic w_access;

    assign w_start   = w_bus_go && !r_active;
    assign w_restart = w_bus_go &&  r_active && w_changed;
    // Debug ownership must hold the counter even when the bus is idle.
    assign w_freeze  = dbg_en || w_err;
    assign w_clear   = !w_req && !dbg_en;
    assign w_access  = w_bus_go && w_done;

    ram_latency_counter #(
        .LAT   (LAT),
        .CNT_W (CNT_W)
    ) u_counter (
        .CLK     (CLK),
        .nRST    (nRST),
        .start   (w_start),
        .restart (w_restart),
        .freeze  (w_freeze),
        .clear   (w_clear),
        .done    (w_done)
    );

    // ------------------------------------------------------------------
    // Handshake and read data toward the bus
    // ------------------------------------------------------------------
    // Debug ownership outranks everything, then idle, then error; a valid
    // request shows BUSY until its count reaches LAT. Reset forces FREE.
    always_comb begin
        ramstate = FREE;
        ramload  = '0;
        if (!nRST) begin
            ramstate = FREE;
        end else if (dbg_en) begin
            ramstate = BUSY;
        end else if (!w_req) begin
            ramstate = FREE;
        end else if (w_err) begin
            ramstate = ERROR;
        end else if (w_done) begin
            ramstate = ACCESS;
            if (ramREN) begin
                ramload = r_mem[w_bus_idx];
            end
        end else begin
            ramstate = BUSY;
        end
    end

    // Debug read is a plain combinational look-up, zero when out of range.
    always_comb begin
        dbg_load = '0;
        if (w_dbg_in_range) begin
            dbg_load = r_mem[w_dbg_idx];
        end
    end

    // ------------------------------------------------------------------
    // Request snapshot and active flag
    // ------------------------------------------------------------------
    // The snapshot follows every bus-owned valid request so a later field
    // change is detected as a restart. The active flag drops after ACCESS,
    // so an unchanged request held one more cycle starts afresh.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_snap_addr  <= '0;
            r_snap_store <= '0;
            r_snap_ren   <= 1'b0;
            r_snap_wen   <= 1'b0;
            r_active     <= 1'b0;
        end else if (dbg_en || !w_req) begin
            r_active     <= 1'b0;
        end else if (w_valid) begin
            r_snap_addr  <= ramaddr;
            r_snap_store <= ramstore;
            r_snap_ren   <= ramREN;
            r_snap_wen   <= ramWEN;
            r_active     <= !w_done;
        end
    end

    // ------------------------------------------------------------------
    // Array update
    // ------------------------------------------------------------------
    // Debug writes and bus write-ACCESS are mutually exclusive because debug
    // ownership suppresses ACCESS; out-of-range debug writes are dropped.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (dbg_en) begin
            if (dbg_wen && w_dbg_in_range) begin
                r_mem[w_dbg_idx] <= dbg_store;
            end
        end else if (w_access && ramWEN) begin
            r_mem[w_bus_idx] <= ramstore;
        end
    end

endmodule : ram_latency_unit
`default_nettype wire
